// File: rtl/ofa_pkg.sv
// ofa_pkg: shared constants and carry helpers for the full-adder cell family.
package ofa_pkg;

   // Value the output registers take while reset is asserted.
   localparam logic RESET_VAL = 1'b0;

   // Carry out from propagate/generate terms, reusable by lookahead adders.
   function automatic logic fa_carry(input logic p, input logic g, input logic cin);
      return g | (p & cin);
   endfunction

   // Full-adder sum from propagate and carry in.
   function automatic logic fa_sum(input logic p, input logic cin);
      return p ^ cin;
   endfunction

endpackage : ofa_pkg

// File: rtl/ofa_if.sv
// ofa_if: bundle of the full-adder operand and result signals.
// The master drives the operands; the slave (the adder cell) returns the results.
interface ofa_if;
   logic a;
   logic b;
   logic cin;
   logic sum;
   logic cout;
   logic p;
   logic g;
   logic sum_q;
   logic cout_q;

   modport master (
      output a, b, cin,
      input  sum, cout, p, g, sum_q, cout_q
   );

   modport slave (
      input  a, b, cin,
      output sum, cout, p, g, sum_q, cout_q
   );
endinterface : ofa_if

// File: rtl/ofa_half.sv
// ofa_half: half adder, s = x ^ y, c = x & y.
module ofa_half (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule : ofa_half

// File: rtl/ofa.sv
// ofa: single-bit full adder with propagate/generate terms and a registered
// copy of the result. REG_OUT selects whether sum/cout come from the
// combinational core (0) or from the output registers (1).
module ofa
   import ofa_pkg::*;
#(
   parameter int unsigned REG_OUT = 0
) (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout,
   input  logic clk,
   input  logic rst,
   output logic p,
   output logic g,
   output logic sum_q,
   output logic cout_q
);

   logic s;
   logic c;
   logic c_prop;

   // First half adder forms propagate and generate from the operands.
   ofa_half u_half_ab (
      .x (a),
      .y (b),
      .s (p),
      .c (g)
   );

   // Second half adder folds in the carry; its carry is the propagated-carry term.
   ofa_half u_half_pc (
      .x (p),
      .y (cin),
      .s (s),
      .c (c_prop)
   );

   assign c = g | c_prop;

   // Capture the combinational result every edge; async reset clears it at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: state is updated with <= so every register samples pre-edge values.
         sum_q  <= RESET_VAL;
         cout_q <= RESET_VAL;
      end else begin
         sum_q  <= s;
         cout_q <= c;
      end
   end

   // Output selection is fixed at elaboration, so the combinational path
   // never depends on clk/rst when REG_OUT is 0.
   if (REG_OUT != 0) begin : g_reg_out
      assign sum  = sum_q;
      assign cout = cout_q;
   end else begin : g_comb_out
      assign sum  = s;
      assign cout = c;
   end

endmodule : ofa

// File: tb/tb_ofa.sv
// tb_ofa: directed checks of the ofa full-adder cell in combinational,
// registered and ripple-chain use, with a queue of expected results.
module tb_ofa;

   logic clk;
   logic rst;

   ofa_if bus ();   // REG_OUT = 0 cell
   ofa_if rbus ();  // REG_OUT = 1 cell

   // Two-bit ripple chain built from two combinational cells.
   logic [1:0] ra;
   logic [1:0] rb;
   logic [1:0] r_sum;
   logic       r_c0;
   logic       r_cout;
   logic [1:0] r_p;
   logic [1:0] r_g;
   logic [1:0] r_sq;
   logic [1:0] r_cq;

   int n_checks = 0;
   int n_pass   = 0;
   logic [1:0] exp_q[$];

   ofa #(.REG_OUT(0)) dut_comb (
      .a(bus.a), .b(bus.b), .cin(bus.cin), .sum(bus.sum), .cout(bus.cout),
      .clk(clk), .rst(rst), .p(bus.p), .g(bus.g),
      .sum_q(bus.sum_q), .cout_q(bus.cout_q)
   );

   ofa #(.REG_OUT(1)) dut_reg (
      .a(rbus.a), .b(rbus.b), .cin(rbus.cin), .sum(rbus.sum), .cout(rbus.cout),
      .clk(clk), .rst(rst), .p(rbus.p), .g(rbus.g),
      .sum_q(rbus.sum_q), .cout_q(rbus.cout_q)
   );

   ofa #(.REG_OUT(0)) rip0 (
      .a(ra[0]), .b(rb[0]), .cin(1'b0), .sum(r_sum[0]), .cout(r_c0),
      .clk(clk), .rst(rst), .p(r_p[0]), .g(r_g[0]),
      .sum_q(r_sq[0]), .cout_q(r_cq[0])
   );

   ofa #(.REG_OUT(0)) rip1 (
      .a(ra[1]), .b(rb[1]), .cin(r_c0), .sum(r_sum[1]), .cout(r_cout),
      .clk(clk), .rst(rst), .p(r_p[1]), .g(r_g[1]),
      .sum_q(r_sq[1]), .cout_q(r_cq[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic sb_pop(input string tag, input logic [1:0] obs);
      logic [1:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         $error("FAIL %s: observed %b expected <empty scoreboard>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         check(tag, {1'b0, obs}, {1'b0, e});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned tot;
      int unsigned ab;

      rst = 1'b1;
      bus.a = 1'b0; bus.b = 1'b0; bus.cin = 1'b0;
      rbus.a = 1'b0; rbus.b = 1'b0; rbus.cin = 1'b0;
      ra = 2'b00; rb = 2'b00;

      // Reset is visible without any clock edge.
      #1;
      check("rst_q_comb", {1'b0, bus.cout_q, bus.sum_q}, 3'b000);
      check("rst_q_reg",  {1'b0, rbus.cout_q, rbus.sum_q}, 3'b000);
      check("rst_out_reg", {1'b0, rbus.cout, rbus.sum}, 3'b000);

      // Exhaustive truth table with rst held high: combinational outputs unaffected.
      for (int i = 0; i < 8; i++) begin
         bus.a   = i[2];
         bus.b   = i[1];
         bus.cin = i[0];
         tot = 32'(i[2]) + 32'(i[1]) + 32'(i[0]);
         ab  = 32'(i[2]) + 32'(i[1]);
         exp_q.push_back(tot[1:0]);
         #1;
         sb_pop($sformatf("truth_%0d", i), {bus.cout, bus.sum});
         check($sformatf("pg_%0d", i), {1'b0, bus.p, bus.g},
               {1'b0, (ab == 1), (ab == 2)});
      end

      // Two-bit ripple: carry of bit 0 feeds bit 1.
      for (int k = 0; k < 4; k++) begin
         logic [3:0] pair;
         logic [2:0] rtot;
         pair = (k == 0) ? 4'b0000 : (k == 1) ? 4'b0111 : (k == 2) ? 4'b1011 : 4'b1111;
         ra = pair[3:2];
         rb = pair[1:0];
         rtot = {1'b0, ra} + {1'b0, rb};
         exp_q.push_back(rtot[1:0]);
         #1;
         check($sformatf("ripple_cout_%0d", k), {2'b00, r_cout}, {2'b00, rtot[2]});
         sb_pop($sformatf("ripple_sum_%0d", k), r_sum);
      end

      // Registered path: release reset away from the edge, then capture 1+1+0.
      @(negedge clk);
      rst = 1'b0;
      bus.a = 1'b1; bus.b = 1'b1; bus.cin = 1'b0;
      exp_q.push_back(2'b10);
      #1;
      check("q_before_edge", {1'b0, bus.cout_q, bus.sum_q}, 3'b000);
      @(posedge clk);
      #1;
      sb_pop("q_110", {bus.cout_q, bus.sum_q});

      bus.a = 1'b1; bus.b = 1'b0; bus.cin = 1'b0;
      exp_q.push_back(2'b01);
      @(posedge clk);
      #1;
      sb_pop("q_100", {bus.cout_q, bus.sum_q});

      // Async reset between edges clears the registers only.
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_q", {1'b0, bus.cout_q, bus.sum_q}, 3'b000);
      check("mid_rst_comb", {1'b0, bus.cout, bus.sum}, 3'b001);
      @(posedge clk);
      #1;
      check("rst_hold_q", {1'b0, bus.cout_q, bus.sum_q}, 3'b000);

      // REG_OUT = 1: outputs follow the registers with one-cycle latency.
      @(negedge clk);
      rst = 1'b0;
      rbus.a = 1'b1; rbus.b = 1'b1; rbus.cin = 1'b1;
      exp_q.push_back(2'b11);
      @(posedge clk);
      #1;
      sb_pop("reg_111", {rbus.cout, rbus.sum});

      @(negedge clk);
      rbus.a = 1'b0; rbus.b = 1'b1; rbus.cin = 1'b1;
      exp_q.push_back(2'b10);
      #1;
      check("reg_hold_old", {1'b0, rbus.cout, rbus.sum}, 3'b011);
      check("reg_pg_comb", {1'b0, rbus.p, rbus.g}, 3'b010);
      @(posedge clk);
      #1;
      sb_pop("reg_011", {rbus.cout, rbus.sum});

      check("sb_drained", {1'b0, 2'(exp_q.size())}, 3'b000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_ofa
